// File: rtl/clock_enables.sv
// Clock-enable and reset sequencer for the 7 MHz system domain.
// Derives the pixel, CPU and PSG enables, a stretched reset, and the turbo switch.
module clock_enables #(
  parameter int RESET_CYCLES = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       turbo,
  input  logic       contend,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic       ce_psg,
  output logic       reset_out,
  output logic       turbo_act,
  output logic [2:0] phase
);

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] RC_W = CW'(RESET_CYCLES);

  logic [2:0]    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_pix_q, ce_pix_d;
  logic          ce_cpu_q, ce_cpu_d;
  logic          ce_psg_q, ce_psg_d;
  logic          reset_out_q, reset_out_d;
  logic          turbo_act_q, turbo_act_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q     <= 3'd0;
      cnt_q       <= '0;
      ce_pix_q    <= 1'b0;
      ce_cpu_q    <= 1'b0;
      ce_psg_q    <= 1'b0;
      reset_out_q <= 1'b1;
      turbo_act_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      ce_pix_q    <= ce_pix_d;
      ce_cpu_q    <= ce_cpu_d;
      ce_psg_q    <= ce_psg_d;
      reset_out_q <= reset_out_d;
      turbo_act_q <= turbo_act_d;
    end
  end

  always_comb begin
    phase_d     = phase_q + 3'd1;
    ce_pix_d    = 1'b1;
    ce_psg_d    = (phase_q[1:0] == 2'd3);
    cnt_d       = (cnt_q == RC_W) ? cnt_q : cnt_q + CW'(1);
    reset_out_d = (cnt_d != RC_W);
    // Turbo only switches on the 8-cycle boundary so the CPU never sees a runt slot.
    turbo_act_d = (phase_q == 3'd7) ? turbo : turbo_act_q;
    // Gating on the current reset_out keeps the first CPU slot strictly after the fall.
    ce_cpu_d    = !reset_out_q && !contend && (turbo_act_d || phase_d[0]);
  end

  assign ce_pix    = ce_pix_q;
  assign ce_cpu    = ce_cpu_q;
  assign ce_psg    = ce_psg_q;
  assign reset_out = reset_out_q;
  assign turbo_act = turbo_act_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_clock_enables.sv
// Randomized self-checking bench for clock_enables, two instances (RESET_CYCLES 16 and 1).
module tb_clock_enables;

  logic clk = 1'b0;
  logic rst, turbo, contend;

  logic       a_pix, a_cpu, a_psg, a_ro, a_tact;
  logic [2:0] a_phase;
  logic       b_pix, b_cpu, b_psg, b_ro, b_tact;
  logic [2:0] b_phase;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset release, applied turbo, contend seen at last edge.
  int n;
  bit tact;
  bit last_con;

  always #5 clk = ~clk;

  clock_enables #(.RESET_CYCLES(16)) dut_a (
    .clock(clk), .reset(rst), .turbo(turbo), .contend(contend),
    .ce_pix(a_pix), .ce_cpu(a_cpu), .ce_psg(a_psg), .reset_out(a_ro),
    .turbo_act(a_tact), .phase(a_phase)
  );

  clock_enables #(.RESET_CYCLES(1)) dut_b (
    .clock(clk), .reset(rst), .turbo(turbo), .contend(contend),
    .ce_pix(b_pix), .ce_cpu(b_cpu), .ce_psg(b_psg), .reset_out(b_ro),
    .turbo_act(b_tact), .phase(b_phase)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0d want %0d", tag, n, obs, exp);
    end
  endtask

  function automatic int exp_ro(input int rc);
    return (n < rc) ? 1 : 0;
  endfunction

  function automatic int exp_cpu(input int rc);
    if (n < 1) return 0;
    if ((n - 1) < rc) return 0;
    if (last_con) return 0;
    return (tact || (n % 2 == 1)) ? 1 : 0;
  endfunction

  task automatic check_all();
    int ph, pix, psg;
    ph  = n % 8;
    pix = (n >= 1) ? 1 : 0;
    psg = (n >= 4 && n % 4 == 0) ? 1 : 0;
    chk("a_phase", int'(a_phase), ph);
    chk("a_ce_pix", int'(a_pix), pix);
    chk("a_ce_psg", int'(a_psg), psg);
    chk("a_turbo_act", int'(a_tact), int'(tact));
    chk("a_reset_out", int'(a_ro), exp_ro(16));
    chk("a_ce_cpu", int'(a_cpu), exp_cpu(16));
    chk("b_phase", int'(b_phase), ph);
    chk("b_ce_pix", int'(b_pix), pix);
    chk("b_ce_psg", int'(b_psg), psg);
    chk("b_turbo_act", int'(b_tact), int'(tact));
    chk("b_reset_out", int'(b_ro), exp_ro(1));
    chk("b_ce_cpu", int'(b_cpu), exp_cpu(1));
  endtask

  // Called at a negedge: drive inputs, let one active edge pass, check at the next negedge.
  task automatic cycle(input bit t, input bit c);
    turbo   = t;
    contend = c;
    @(posedge clk);
    if (!rst) begin
      if (n % 8 == 7) tact = t;
      n++;
      last_con = c;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_phase(input int ph, input bit t);
    for (int i = 0; i < 8 && (n % 8) != ph; i++) cycle(t, 1'b0);
  endtask

  initial begin
    bit t;
    rst = 1'b1; turbo = 1'b0; contend = 1'b0;
    n = 0; tact = 1'b0; last_con = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    rst = 1'b0;

    // Stretch release and steady state in normal mode.
    for (int i = 0; i < 24 + 64; i++) cycle(1'b0, 1'b0);

    // Turbo request raised at phase 3, applied at the phase-7 edge.
    run_until_phase(3, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    // Short drop at phase 2 while in turbo: no change applied.
    run_until_phase(2, 1'b1);
    cycle(1'b0, 1'b0); cycle(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0);
    // Back to normal, then a short turbo pulse at phase 2 that must be ignored.
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0);
    run_until_phase(2, 1'b0);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);

    // Three cycles of contention in normal mode.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);

    // Contention at a turbo boundary.
    run_until_phase(7, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0);

    // Random traffic.
    t = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) t = ~t;
      cycle(t, ($urandom_range(3) == 0));
    end

    // Asynchronous reset between edges at phase 5.
    run_until_phase(5, t);
    #2;
    rst = 1'b1;
    #1;
    n = 0; tact = 1'b0; last_con = 1'b0;
    check_all();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(t, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(7) == 0) t = ~t;
      cycle(t, ($urandom_range(4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
